load_store_unit: RTL and testbench

Sequencer between the MEM pipeline stage and the word-organised data memory (128 × 32-bit, byte address 9 bits, level-sensitive `MemRead`/`MemWrite`). It accepts one load or store per request. It performs byte, halfword and word accesses: subword stores use read-modify-write, and loads are extracted, sign-extended or zero-extended. All memory-side signals are driven from registers, so the memory sees stable address and data for a full cycle.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_lane_merge.sv | 36 +++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and its lane helper.
// Holds the access-size codes and the sequencer state encoding.
// Also used by the datapath that reuses lsu_lane_merge.
package lsu_pkg;

   localparam logic [1:0] LSU_SZ_BYTE = 2'b00;
   localparam logic [1:0] LSU_SZ_HALF = 2'b01;
   localparam logic [1:0] LSU_SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_RD   = 2'd1,
      LSU_WR   = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_t;

   // Size code 2'b11 behaves as a word, so only the top bit matters
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Purpose: byte/half lane patching for stores and lane extract/extend for loads.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_merge
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  offs,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] merged,
   output logic [31:0] extracted
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Pick the addressed little-endian lane(s), then patch them in or widen them to 32 bits
   always_comb begin
      merged    = word;
      extracted = word;
      lane_b    = word[{offs, 3'b000} +: 8];
      lane_h    = word[{offs[1], 4'b0000} +: 16];
      if (size == LSU_SZ_BYTE) begin
         merged[{offs, 3'b000} +: 8] = wdata[7:0];
         extracted = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      end else if (size == LSU_SZ_HALF) begin
         merged[{offs[1], 4'b0000} +: 16] = wdata[15:0];
         extracted = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      end else begin
         merged = wdata;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: sequences one load/store at a time onto a word-wide, level-sensitive data memory.
// Latency: load 2, word store 2, subword store 3 cycles from acceptance (misaligned trap 1).
// Backpressure: req_ready only in IDLE; requester holds req_* until accepted. Option: LSU_MISALIGN_TRAP_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   lsu_state_t        state, state_nxt;
   logic              accept;
   logic              misalign;
   logic [ADDR_W-1:0] addr_algn;
   logic              we_q, uns_q;
   logic [1:0]        size_q;
   logic              mem_read_d, mem_write_d, resp_valid_d;
   logic [31:0]       merged, extracted;

   assign req_ready = (state == LSU_IDLE) & ~rst;
   assign accept    = req_valid & req_ready;

   // Either flag a misaligned access or round the address down to natural alignment
   always_comb begin
      addr_algn = req_addr;
      misalign  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_size == LSU_SZ_HALF) misalign = req_addr[0];
      else if (is_word(req_size))  misalign = |req_addr[1:0];
`else
      if (req_size == LSU_SZ_HALF) addr_algn[0] = 1'b0;
      else if (is_word(req_size))  addr_algn[1:0] = 2'b00;
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= LSU_IDLE;
      else     state <= state_nxt;
   end

   // Next state: word stores skip the read, subword stores read then write
   always_comb begin
      state_nxt = state;
      case (state)
         LSU_IDLE: begin
            if (accept) begin
               if (misalign)                         state_nxt = LSU_DONE;
               else if (req_we & is_word(req_size))  state_nxt = LSU_WR;
               else                                  state_nxt = LSU_RD;
            end
         end
         LSU_RD:   state_nxt = we_q ? LSU_WR : LSU_DONE;
         LSU_WR:   state_nxt = LSU_DONE;
         LSU_DONE: state_nxt = LSU_IDLE;
         default:  state_nxt = LSU_IDLE;
      endcase
   end

   // Memory strobes and response are decoded from the upcoming state so they can be registered
   always_comb begin
      mem_read_d   = (state_nxt == LSU_RD);
      mem_write_d  = (state_nxt == LSU_WR);
      resp_valid_d = (state_nxt == LSU_DONE);
   end

   lsu_lane_merge u_lane (
      .size        (size_q),
      .is_unsigned (uns_q),
      .offs        (mem_addr[1:0]),
      .word        (mem_rdata),
      .wdata       (mem_wdata),
      .merged      (merged),
      .extracted   (extracted)
   );

   // Registered memory side; mem_wdata parks the store data until RD replaces it with the merged word
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         resp_valid <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_rdata <= '0;
         we_q       <= 1'b0;
         size_q     <= LSU_SZ_BYTE;
         uns_q      <= 1'b0;
      end else begin
         mem_read   <= mem_read_d;
         mem_write  <= mem_write_d;
         resp_valid <= resp_valid_d;
         if (accept) begin
            we_q     <= req_we;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            mem_addr <= addr_algn;
            if (req_we) mem_wdata <= req_wdata;
         end
         if (state == LSU_RD) begin
            if (we_q) mem_wdata  <= merged;
            else      resp_rdata <= extracted;
         end
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic resp_err_q;

   // A trapped request is the only path that goes straight from IDLE to DONE
   always_ff @(posedge clk) begin
      if (rst) resp_err_q <= 1'b0;
      else     resp_err_q <= (state == LSU_IDLE) & (state_nxt == LSU_DONE);
   end
   assign resp_err = resp_err_q;
`else
   assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, per-request expectation tables keyed by cycle.
// Directed cases from the feature list, a reset-in-RD abort, then randomized traffic.
// Misalignment expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [8:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
   logic [31:0] resp_rdata, mem_wdata, mem_rdata;
   logic [8:0]  mem_addr;

   logic [31:0] mem [128];
   logic [31:0] ref_mem [128];
   logic [31:0] last_ld = '0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct { logic [8:0] a; logic [31:0] d; } wr_t;
   typedef struct { logic [31:0] d; logic e; } rsp_t;
   logic [8:0] exp_rd [int];
   wr_t        exp_wr [int];
   rsp_t       exp_resp [int];
   bit         e_rd, e_wr, e_rs;

   load_store_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Level-sensitive word memory: write lands while MemWrite is high, read is combinational
   always @(posedge clk) if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[8:2]];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic logic [31:0] m_extract(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] off);
      logic [31:0] v;
      if (sz == 2'b00) begin
         v = (w >> (8 * off)) & 32'hFF;
         if (!uns && v > 32'd127) v = v + 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
         v = (w >> (16 * off[1])) & 32'hFFFF;
         if (!uns && v > 32'd32767) v = v + 32'hFFFF0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic [31:0] d);
      logic [31:0] mask;
      int          sh;
      if (sz == 2'b00)      begin sh = 8 * off;     mask = 32'hFF   << sh; end
      else if (sz == 2'b01) begin sh = 16 * off[1]; mask = 32'hFFFF << sh; end
      else                  begin sh = 0;           mask = 32'hFFFFFFFF;  end
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   // Compare process: every cycle, strobes/address/data/response against the expectation tables
   always @(negedge clk) begin
      e_rd = exp_rd.exists(cyc) != 0;
      e_wr = exp_wr.exists(cyc) != 0;
      e_rs = exp_resp.exists(cyc) != 0;
      chk($sformatf("mem_read@%0d", cyc), 32'(mem_read), 32'(e_rd));
      chk($sformatf("mem_write@%0d", cyc), 32'(mem_write), 32'(e_wr));
      chk($sformatf("resp_valid@%0d", cyc), 32'(resp_valid), 32'(e_rs));
      if (e_rd) chk($sformatf("rd_addr@%0d", cyc), 32'(mem_addr), 32'(exp_rd[cyc]));
      if (e_wr) begin
         chk($sformatf("wr_addr@%0d", cyc), 32'(mem_addr), 32'(exp_wr[cyc].a));
         chk($sformatf("wr_data@%0d", cyc), mem_wdata, exp_wr[cyc].d);
      end
      if (e_rs) begin
         chk($sformatf("resp_rdata@%0d", cyc), resp_rdata, exp_resp[cyc].d);
         chk($sformatf("resp_err@%0d", cyc), 32'(resp_err), 32'(exp_resp[cyc].e));
      end
   end

   // Issue one request (called at a falling edge); abort=1 resets the DUT during RD of a subword store
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [8:0] addr,
                        input logic [31:0] wd, input bit abort, output logic [31:0] rd, output logic er);
      int          c;
      bit          got;
      bit          mis;
      logic [8:0]  a;
      logic [31:0] w, nw, ld;
      rd = '0;
      er = 1'b0;
      req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (req_ready) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept: req_ready got 0 want 1");
         req_valid = 1'b0;
         return;
      end
      c   = cyc;
      a   = addr;
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
      if (sz == 2'b01) a[0] = 1'b0;
      else if (sz[1])  a[1:0] = 2'b00;
`endif
      w = ref_mem[a[8:2]];
      if (mis) begin
         exp_resp[c+1] = '{last_ld, 1'b1};
      end else if (!we) begin
         exp_rd[c+1]   = a;
         ld            = m_extract(w, sz, uns, a[1:0]);
         last_ld       = ld;
         exp_resp[c+2] = '{ld, 1'b0};
      end else if (sz[1]) begin
         exp_wr[c+1]        = '{a, wd};
         ref_mem[a[8:2]]    = wd;
         exp_resp[c+2]      = '{last_ld, 1'b0};
      end else begin
         exp_rd[c+1] = a;
         if (!abort) begin
            nw               = m_merge(w, sz, a[1:0], wd);
            exp_wr[c+2]      = '{a, nw};
            ref_mem[a[8:2]]  = nw;
            exp_resp[c+3]    = '{last_ld, 1'b0};
         end
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (abort) begin
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         chk("ready_in_rst", 32'(req_ready), 32'd0);
         rst = 1'b0;
         @(negedge clk);
         chk("ready_after_rst", 32'(req_ready), 32'd1);
         return;
      end
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
            rd  = resp_rdata;
            er  = resp_err;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got no resp_valid want resp_valid");
      end
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_out_of_reset", 32'(req_ready), 32'd1);

      for (int i = 0; i < 128; i++)
         issue(1'b1, LSU_SZ_WORD, 1'b0, 9'(i * 4), $urandom, 1'b0, r, e);

      issue(1'b1, LSU_SZ_WORD, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0, r, e);
      issue(1'b0, LSU_SZ_WORD, 1'b0, 9'h010, 32'h0, 1'b0, r, e);
      chk("word_load", r, 32'hDEADBEEF);

      issue(1'b1, LSU_SZ_WORD, 1'b0, 9'h020, 32'h11223344, 1'b0, r, e);
      issue(1'b1, LSU_SZ_BYTE, 1'b0, 9'h022, 32'h000000AA, 1'b0, r, e);
      chk("byte_rmw_word", mem[8], 32'h11AA3344);
      issue(1'b0, LSU_SZ_BYTE, 1'b0, 9'h022, 32'h0, 1'b0, r, e);
      chk("byte_load_signed", r, 32'hFFFFFFAA);
      issue(1'b0, LSU_SZ_BYTE, 1'b1, 9'h022, 32'h0, 1'b0, r, e);
      chk("byte_load_unsigned", r, 32'h000000AA);

      issue(1'b1, LSU_SZ_WORD, 1'b0, 9'h000, 32'h80017FFF, 1'b0, r, e);
      issue(1'b0, LSU_SZ_HALF, 1'b0, 9'h002, 32'h0, 1'b0, r, e);
      chk("half_load_hi_signed", r, 32'hFFFF8001);
      issue(1'b0, LSU_SZ_HALF, 1'b0, 9'h000, 32'h0, 1'b0, r, e);
      chk("half_load_lo", r, 32'h00007FFF);

      issue(1'b0, LSU_SZ_WORD, 1'b0, 9'h013, 32'h0, 1'b0, r, e);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misaligned_err", 32'(e), 32'd1);
      chk("misaligned_rdata_held", r, 32'h00007FFF);
`else
      chk("misaligned_err", 32'(e), 32'd0);
      chk("misaligned_aligned_read", r, 32'hDEADBEEF);
`endif

      issue(1'b1, LSU_SZ_BYTE, 1'b0, 9'h011, 32'h00000055, 1'b1, r, e);
      issue(1'b0, LSU_SZ_WORD, 1'b0, 9'h010, 32'h0, 1'b0, r, e);
      chk("abort_mem_untouched", r, 32'hDEADBEEF);

      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
               9'($urandom_range(0, 511)), $urandom, 1'b0, r, e);
      end

      repeat (2) @(negedge clk);
      for (int i = 0; i < 128; i++)
         chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
